vga_frame_scheduler: RTL and testbench

- Shares the VGA capture front end between NUM_REQ frame consumers (SIFT octave builder, debug framebuffer, etc.).
- Arbitrates requests round-robin and sequences the capture block's four-phase start/start_ack and done/done_ack handshakes, one full frame per grant.
- Routes the capture block's per-pixel valid strobe to the granted consumer and checks the pixel count per frame.

---
 rtl/vga_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/vga_frame_scheduler.sv | 143 ++++++++++++++
 tb/tb_vga_frame_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA frame geometry and scheduler state encoding
package vga_pkg;

  localparam int WIDTH            = 800;
  localparam int HEIGHT           = 600;
  localparam int PIXELS_PER_FRAME = WIDTH * HEIGHT;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    RELEASE,
    CAPTURE,
    ACK,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set req at or after pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  int         sum;
  logic [IDX_W-1:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(pointer) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - round-robin sharing of the VGA capture block, one frame per grant
// Optional grant-to-done watchdog: define VGA_SCHED_TIMEOUT_EN.
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int PIXELS_PER_FRAME = vga_pkg::PIXELS_PER_FRAME,
  parameter int CNT_W            = 20,
  parameter int TIMEOUT_CYCLES   = 2000000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] frame_done,
  output logic               frame_error,
  output logic               busy,
  output logic [15:0]        frame_count,
  output logic [NUM_REQ-1:0] pixel_valid,
  output logic               vga_start,
  input  logic               vga_start_ack,
  input  logic               vga_done,
  output logic               vga_done_ack,
  input  logic               vga_video_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_next;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   pix_cnt;
  logic               expired;
  logic               timed_out;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req    (req),
    .pointer(rr_ptr),
    .grant  (arb_grant),
    .index  (arb_idx)
  );

`ifdef VGA_SCHED_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_fire;

  assign expired = (to_cnt >= 32'(TIMEOUT_CYCLES - 1));
  // A jump to ACK/DONE from these states only happens through the watchdog
  assign to_fire = ((state == START || state == RELEASE) &&
                    (state_next == ACK || state_next == DONE)) ||
                   (state == CAPTURE && state_next == DONE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ARB) begin
        to_cnt    <= '0;
        timed_out <= 1'b0;
      end else if ((state == START || state == RELEASE || state == CAPTURE) && !expired) begin
        to_cnt <= to_cnt + 32'd1;
      end
      if (to_fire) timed_out <= 1'b1;
    end
  end
`else
  assign expired   = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = ARB;
      ARB:     state_next = (|req) ? START : IDLE;
      START: begin
        if (vga_start_ack) state_next = RELEASE;
        else if (expired)  state_next = vga_done ? ACK : DONE;
      end
      RELEASE: begin
        if (!vga_start_ack) begin
          if (expired) state_next = vga_done ? ACK : DONE;
          else         state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vga_done)     state_next = ACK;
        else if (expired) state_next = DONE;
      end
      ACK:     if (!vga_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant       <= '0;
      grant_idx   <= '0;
      rr_ptr      <= '0;
      pix_cnt     <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        ARB: begin
          grant     <= arb_grant;
          grant_idx <= arb_idx;
          pix_cnt   <= '0;
        end
        CAPTURE: begin
          if (vga_video_valid && pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
        end
        DONE: begin
          frame_count <= frame_count + 16'd1;
          rr_ptr      <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          grant       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign vga_start    = (state == START);
  assign vga_done_ack = (state == ACK);
  assign frame_done   = (state == DONE) ? grant : '0;
  assign frame_error  = (state == DONE) &&
                        ((pix_cnt != CNT_W'(PIXELS_PER_FRAME)) || timed_out);
  // Zero-latency gate so strobes line up with the capture block's video data
  assign pixel_valid  = (state == CAPTURE) ? (grant & {NUM_REQ{vga_video_valid}}) : '0;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb/tb_vga_frame_scheduler.sv - directed self-checking bench for vga_frame_scheduler
module tb_vga_frame_scheduler;

  localparam int NREQ = 2;
  localparam int PPF  = 20;
  localparam int CW   = 8;
  localparam int TO   = 100;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] frame_done;
  logic            frame_error;
  logic            busy;
  logic [15:0]     frame_count;
  logic [NREQ-1:0] pixel_valid;
  logic            vga_start;
  logic            vga_start_ack = 1'b0;
  logic            vga_done = 1'b0;
  logic            vga_done_ack;
  logic            vga_video_valid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vga_frame_scheduler #(
    .NUM_REQ         (NREQ),
    .PIXELS_PER_FRAME(PPF),
    .CNT_W           (CW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock          (clk),
    .reset_n        (reset_n),
    .req            (req),
    .grant          (grant),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .busy           (busy),
    .frame_count    (frame_count),
    .pixel_valid    (pixel_valid),
    .vga_start      (vga_start),
    .vga_start_ack  (vga_start_ack),
    .vga_done       (vga_done),
    .vga_done_ack   (vga_done_ack),
    .vga_video_valid(vga_video_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_start(input string tag);
    int waited;
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      waited++;
      if (vga_start) break;
    end
    check({tag, "_start_seen"}, 32'(vga_start), 32'd1);
  endtask

  task automatic do_frame(input string tag, input int npix, input logic [NREQ-1:0] exp_grant,
                          input logic exp_err, input logic [NREQ-1:0] req_mid,
                          input logic [NREQ-1:0] req_end);
    wait_start(tag);
    req             = req_mid;
    vga_video_valid = 1'b1;
    vga_done        = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_pv_start"}, 32'(pixel_valid), 32'd0);
    vga_start_ack = 1'b1;
    @(negedge clk);
    check({tag, "_start_release"}, 32'(vga_start), 32'd0);
    check({tag, "_pv_release"}, 32'(pixel_valid), 32'd0);
    vga_start_ack   = 1'b0;
    vga_done        = 1'b0;
    vga_video_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < npix; i++) begin
      vga_video_valid = 1'b1;
      if (i == 0) begin
        #1;
        check({tag, "_pv_capture"}, 32'(pixel_valid), 32'(exp_grant));
      end
      @(negedge clk);
    end
    vga_video_valid = 1'b0;
    vga_done        = 1'b1;
    @(negedge clk);
    check({tag, "_done_ack"}, 32'(vga_done_ack), 32'd1);
    vga_video_valid = 1'b1;
    #1;
    check({tag, "_pv_ack"}, 32'(pixel_valid), 32'd0);
    vga_done = 1'b0;
    @(negedge clk);
    check({tag, "_frame_done"}, 32'(frame_done), 32'(exp_grant));
    check({tag, "_frame_error"}, 32'(frame_error), 32'(exp_err));
    vga_video_valid = 1'b0;
    req             = req_end;
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(frame_done), 32'd0);
    check({tag, "_grant_clear"}, 32'(grant), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(vga_start), 32'd0);
    check("rst_done_ack", 32'(vga_done_ack), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Round-robin with both requesters held
    req = 2'b11;
    do_frame("rr0", PPF, 2'b01, 1'b0, 2'b11, 2'b11);
    do_frame("rr1", PPF, 2'b10, 1'b0, 2'b11, 2'b11);
    do_frame("rr2", PPF, 2'b01, 1'b0, 2'b11, 2'b11);
    do_frame("rr3", PPF, 2'b10, 1'b0, 2'b11, 2'b00);
    check("rr_count", 32'(frame_count), 32'd4);

    // Short frame then clean frame, same requester back to back
    req = 2'b01;
    do_frame("short", PPF - 1, 2'b01, 1'b1, 2'b01, 2'b01);
    do_frame("clean", PPF, 2'b01, 1'b0, 2'b01, 2'b00);
    check("clean_count", 32'(frame_count), 32'd6);
    check("clean_idle", 32'(busy), 32'd0);

    // Owner drops req after ARB; frame still completes
    req = 2'b10;
    do_frame("drop", PPF, 2'b10, 1'b0, 2'b00, 2'b00);
    check("drop_count", 32'(frame_count), 32'd7);

    // Reset in the middle of CAPTURE
    req = 2'b01;
    wait_start("mid");
    vga_start_ack = 1'b1;
    @(negedge clk);
    vga_start_ack = 1'b0;
    @(negedge clk);
    vga_video_valid = 1'b1;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pv", 32'(pixel_valid), 32'd0);
    check("mid_rst_count", 32'(frame_count), 32'd0);
    reset_n         = 1'b1;
    vga_video_valid = 1'b0;
    @(negedge clk);
    check("mid_arb_busy", 32'(busy), 32'd1);
    do_frame("after_rst", PPF, 2'b01, 1'b0, 2'b01, 2'b00);
    check("after_rst_count", 32'(frame_count), 32'd1);

`ifdef VGA_SCHED_TIMEOUT_EN
    begin
      int waited;
      req = 2'b01;
      wait_start("to");
      waited = 0;
      while (waited < TO + 10) begin
        @(negedge clk);
        waited++;
        if (frame_done != '0) break;
      end
      check("to_cycles", 32'(waited), 32'(TO));
      check("to_frame_done", 32'(frame_done), 32'd1);
      check("to_frame_error", 32'(frame_error), 32'd1);
      req = 2'b00;
      @(negedge clk);
      check("to_start_low", 32'(vga_start), 32'd0);
      check("to_busy_low", 32'(busy), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
